// File: rtl/ram_bist_ctrl_if.sv
// RAM-style port bundle: write enable, write data, address and read data.
// The controller is the master on its RAM side and the slave on its user side.
interface ram_bist_ctrl_if;
  logic       w;
  logic [7:0] data_in;
  logic [2:0] data_adr;
  logic [7:0] data_out;

  modport master (output w, output data_in, output data_adr, input data_out);
  modport slave  (input w, input data_in, input data_adr, output data_out);
endinterface

// File: rtl/ram_bist_ctrl.sv
// March C- self-test controller and port arbiter for an 8 x 8-bit RAM.
// While idle the user port passes straight through to the RAM. On start the
// controller owns the RAM, runs the six March elements and reports pass/fail
// with the first failing address, expected byte and observed byte.
module ram_bist_ctrl #(
  parameter logic [7:0] PATTERN = 8'h55
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  ram_bist_ctrl_if.slave  usr,
  ram_bist_ctrl_if.master ram,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2:0]     fail_adr,
  output logic [7:0]     fail_exp,
  output logic [7:0]     fail_got
);

  typedef enum logic [2:0] {IDLE, WR, RD_SETUP, RD_CHK, FINISH} state_t;

  state_t     state_q, state_d;
  logic [2:0] adr_q, adr_d;
  logic [2:0] elem_q, elem_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] fail_adr_q, fail_adr_d;
  logic [7:0] fail_exp_q, fail_exp_d;
  logic [7:0] fail_got_q, fail_got_d;

  // Elements 0..2 walk addresses upward, 3..5 walk downward. Odd elements
  // read bg and write ~bg; even elements read ~bg and write bg.
  logic       descending;
  logic       at_last;
  logic [2:0] adr_step;
  logic [2:0] elem_next;
  logic [2:0] next_first;
  logic [7:0] rd_exp;
  logic [7:0] wr_byte;

  assign descending = (elem_q >= 3'd3);
  assign at_last    = descending ? (adr_q == 3'd0) : (adr_q == 3'd7);
  assign adr_step   = descending ? (adr_q - 3'd1) : (adr_q + 3'd1);
  assign elem_next  = elem_q + 3'd1;
  assign next_first = (elem_next >= 3'd3) ? 3'd7 : 3'd0;
  assign rd_exp     = elem_q[0] ? PATTERN : ~PATTERN;
  assign wr_byte    = elem_q[0] ? ~PATTERN : PATTERN;

  // Port arbitration: the registered busy flag selects the owner, so a reset
  // hands the RAM back to the user port immediately.
  assign ram.w        = busy_q ? (state_q == WR) : usr.w;
  assign ram.data_in  = busy_q ? wr_byte : usr.data_in;
  assign ram.data_adr = busy_q ? adr_q : usr.data_adr;
  assign usr.data_out = ram.data_out;

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_adr = fail_adr_q;
  assign fail_exp = fail_exp_q;
  assign fail_got = fail_got_q;

  // Next-state, counter and result logic for the March sequence.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    elem_d     = elem_q;
    pass_d     = pass_q;
    fail_adr_d = fail_adr_q;
    fail_exp_d = fail_exp_q;
    fail_got_d = fail_got_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WR;
          adr_d      = 3'd0;
          elem_d     = 3'd0;
          pass_d     = 1'b0;
          fail_adr_d = 3'd0;
          fail_exp_d = 8'd0;
          fail_got_d = 8'd0;
        end
      end
      WR: begin
        if (at_last) begin
          elem_d  = elem_next;
          adr_d   = next_first;
          state_d = RD_SETUP;
        end else begin
          adr_d   = adr_step;
          state_d = (elem_q == 3'd0) ? WR : RD_SETUP;
        end
      end
      RD_SETUP: state_d = RD_CHK;
      RD_CHK: begin
        if (ram.data_out != rd_exp) begin
          fail_adr_d = adr_q;
          fail_exp_d = rd_exp;
          fail_got_d = ram.data_out;
          pass_d     = 1'b0;
          state_d    = FINISH;
        end else if (elem_q == 3'd5) begin
          if (at_last) begin
            pass_d  = 1'b1;
            state_d = FINISH;
          end else begin
            adr_d   = adr_step;
            state_d = RD_SETUP;
          end
        end else begin
          state_d = WR;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WR) || (state_d == RD_SETUP) || (state_d == RD_CHK);
    done_d = (state_d == FINISH);
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      adr_q      <= 3'd0;
      elem_q     <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_adr_q <= 3'd0;
      fail_exp_q <= 8'd0;
      fail_got_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      elem_q     <= elem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_adr_q <= fail_adr_d;
      fail_exp_q <= fail_exp_d;
      fail_got_q <= fail_got_d;
    end
  end

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

March-test controller and port arbiter that sits directly upstream of the 8 x 8-bit `RAM` block and drives its `w`, `data_in` and `data_adr` inputs. It also consumes the RAM's `data_out`. When idle, it passes user traffic straight through to the RAM. On `start`, it takes ownership of the RAM and runs a March C- test over all 8 locations. It reports pass/fail with the first failing address, expected byte and observed byte. It is the self-test front end for every RAM instance in the design.

## Interface
- `PATTERN`, default 8'h55: background byte `bg`. The complement `~bg` is the second pattern.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high; also wired to the RAM's `rst`.
- `start`  in  1  begin self-test; sampled only in IDLE.
- `usr_w`  in  1  user write enable; passed through when `busy`=0.
- `usr_data_in`  in  8  user write data.
- `usr_data_adr`  in  3  user address.
- `usr_data_out`  out  8  equals `ram_data_out` at all times.
- `ram_w`  out  1  to RAM `w`.
- `ram_data_in`  out  8  to RAM `data_in`.
- `ram_data_adr`  out  3  to RAM `data_adr`.
- `ram_data_out`  in  8  from RAM `data_out`.
- `busy`  out  1  test in progress; user inputs are ignored.
- `done`  out  1  one-cycle pulse when the test ends.
- `pass`  out  1  result; valid from the `done` cycle and held until the next accepted `start`.
- `fail_adr`  out  3  first failing address.
- `fail_exp`  out  8  expected byte at the first failure.
- `fail_got`  out  8  observed byte at the first failure.

## Operation
- **Arbitration**
  - `busy`=0: `ram_*` = `usr_*`, combinationally.
  - `busy`=1: `ram_*` come from the controller's registers.
- **March sequence.** Each element visits all addresses in order: ⇑ = 0..7, ⇓ = 7..0.
  - M0: ⇑ w(bg)
  - M1: ⇑ r(bg), w(~bg)
  - M2: ⇑ r(~bg), w(bg)
  - M3: ⇓ r(bg), w(~bg)
  - M4: ⇓ r(~bg), w(bg)
  - M5: ⇓ r(bg)
- **FSM states:** IDLE, WR, RD_SETUP, RD_CHK, FINISH.
  - IDLE → WR when `start`=1.
  - WR → RD_SETUP for the next address, or for the next element's first address.
  - RD_SETUP → RD_CHK.
  - RD_CHK → WR (M1–M4), RD_SETUP (M5 next address), or FINISH (last read, or any mismatch).
  - FINISH → IDLE.
- **Read protocol:** address held with `ram_w`=0 for RD_SETUP and RD_CHK. `ram_data_out` is sampled at the rising edge ending RD_CHK. This works for both combinational-read and 1-cycle registered-read RAM.
- **Compare:** exact 8-bit equality against the element's expected byte. On the first mismatch:
  - capture `fail_adr`, `fail_exp`, `fail_got`;
  - abort immediately, with no further RAM writes;
  - go to FINISH with `pass`=0.
- **Counters:** 3-bit address counter with wrap (7+1 → 0 for ⇑, 0−1 → 7 for ⇓), plus a 3-bit element index 0..5.
- **Clean run:** `pass`=1 and `fail_*` = 0. RAM is left holding `bg` in all 8 locations.
- **Ignored inputs:** `start` while `busy`=1 or in FINISH. `usr_w` while `busy`=1, so user writes are dropped, not queued.
- **Reset (any time, including mid-test):**
  - state IDLE; `busy`, `done`, `pass` = 0; `fail_adr`, `fail_exp`, `fail_got` = 0;
  - `ram_*` immediately revert to `usr_*`;
  - RAM contents are unspecified unless the RAM's own reset clears them.

## Timing
- All status outputs are registered. Reset values: `busy`=0, `done`=0, `pass`=0, `fail_*`=0.
- Cycle 1 is the first cycle after the edge that samples `start`=1. In cycle 1, `busy`=1, `ram_w`=1, `ram_data_adr`=0, `ram_data_in`=`bg`.
- Cycle cost:
  - write: 1 cycle;
  - read: 2 cycles;
  - r+w pair: 3 cycles;
  - M0 = 8, M1–M4 = 24 each, M5 = 16.
- A passing run has `busy`=1 for exactly 120 cycles. In cycle 121, `busy`=0, `done`=1 and `pass`=1. `done` deasserts in cycle 122.
- On a failure sampled at the end of cycle k, cycle k+1 has `busy`=0, `done`=1, `pass`=0.
- `start` asserted in the `done` cycle is ignored (FINISH state). `start` asserted in cycle 122 or later is accepted.
- A new accepted `start` clears `pass` and `fail_*` in cycle 1 of the new run.

## Test plan
- **Reset then pass-through:** write `usr_w`=1, adr 3, data 0xDD; then read adr 3 → `usr_data_out`=0xDD. `busy`, `done`, `pass` stay 0.
- **Clean run, fault-free RAM:** pulse `start` → `busy` high exactly 120 cycles; then `done` for 1 cycle with `pass`=1 and `fail_*`=0. All 8 locations then read back 0x55 via the user port.
- **Stuck-at fault:** bench RAM model has bit 3 of address 5 stuck at 0, with `PATTERN`=0x55. Required result:
  - first mismatch in M2 at address 5, sampled at the end of cycle 49;
  - `done` in cycle 50;
  - `pass`=0, `fail_adr`=5, `fail_exp`=0xAA, `fail_got`=0xA2;
  - no RAM write after cycle 49.
- **Ignored user traffic and `start` during a test:**
  - `start` and `usr_w`=1 (adr 2, data 0x00) held during cycles 10–20;
  - run still completes at cycle 121 with `pass`=1;
  - address 2 reads 0x55 afterwards.
- **Reset mid-test:** assert `rst` in cycle 60 → `busy`, `done`, `pass`, `fail_*` go to 0 asynchronously, and `ram_*` follow `usr_*`. A subsequent `start` runs the full 120 cycles and passes.
- **Back-to-back runs:**
  - second `start` in the `done` cycle is ignored;
  - second `start` in cycle 122 gives a second full run;
  - `pass` reads 0 from that run's cycle 1 until its `done`.
